// File: rtl/mul_issue_sched.sv
// Round-robin issue scheduler sharing one combinational XLEN x XLEN multiplier among NUM_REQ ports.
// Build option: define MUL_PRODUCT_RETIME_EN to register the full product (latency 3 instead of 2).
module mul_issue_sched #(
  parameter int NUM_REQ = 2,
  parameter int XLEN    = 32,
  parameter int TAG_W   = 6,
  localparam int SRC_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic [NUM_REQ-1:0]       req_vld,
  output logic [NUM_REQ-1:0]       req_rdy,
  input  logic [2*NUM_REQ-1:0]     req_op,
  input  logic [XLEN*NUM_REQ-1:0]  req_src1,
  input  logic [XLEN*NUM_REQ-1:0]  req_src2,
  input  logic [TAG_W*NUM_REQ-1:0] req_tag,
  output logic                     mul_tc_a,
  output logic                     mul_tc_b,
  output logic [XLEN-1:0]          mul_a,
  output logic [XLEN-1:0]          mul_b,
  input  logic [2*XLEN-1:0]        mul_product,
  output logic                     rsp_vld,
  input  logic                     rsp_rdy,
  output logic [XLEN-1:0]          rsp_data,
  output logic [TAG_W-1:0]         rsp_tag,
  output logic [SRC_W-1:0]         rsp_src
);

  if (NUM_REQ < 1 || NUM_REQ > 8) begin : g_bad_num_req
    $error("mul_issue_sched: NUM_REQ must be in the range 1..8");
  end

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULH   = 2'b01,
    OP_MULHSU = 2'b10,
    OP_MULHU  = 2'b11
  } op_e;

  // Stall chain and arbitration
  logic             s2_adv;
  logic             s1_adv;
  logic             s1_fwd;
  logic             accept;
  logic             grant_vld;
  logic [SRC_W-1:0] grant_idx;
  logic [1:0]       sel_op;
  logic [XLEN-1:0]  sel_src1;
  logic [XLEN-1:0]  sel_src2;
  logic [TAG_W-1:0] sel_tag;
  logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;

  // S1: operand registers feeding the multiplier
  logic             s1_vld_q, s1_vld_d;
  logic             s1_tc_a_q, s1_tc_a_d;
  logic             s1_tc_b_q, s1_tc_b_d;
  logic [XLEN-1:0]  s1_a_q, s1_a_d;
  logic [XLEN-1:0]  s1_b_q, s1_b_d;
  logic             s1_hi_q, s1_hi_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
  logic [SRC_W-1:0] s1_src_q, s1_src_d;

  // Whatever stage sits directly in front of S2
  logic              pre_vld;
  logic [2*XLEN-1:0] pre_prod;
  logic              pre_hi;
  logic [TAG_W-1:0]  pre_tag;
  logic [SRC_W-1:0]  pre_src;

  // S2: response registers
  logic             s2_vld_q, s2_vld_d;
  logic [XLEN-1:0]  s2_data_q, s2_data_d;
  logic [TAG_W-1:0] s2_tag_q, s2_tag_d;
  logic [SRC_W-1:0] s2_src_q, s2_src_d;

  assign s2_adv = !s2_vld_q || rsp_rdy;
  assign s1_adv = !s1_vld_q || s1_fwd;
  assign accept = rst_n && !flush && s1_adv && grant_vld;

  // First valid requester at or after rr_ptr; the offset loop makes the search wrap.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    grant_vld = 1'b0;
    grant_idx = '0;
    sel_op    = '0;
    sel_src1  = '0;
    sel_src2  = '0;
    sel_tag   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!grant_vld && req_vld[i] && (i == (int'(rr_ptr_q) + k) % NUM_REQ)) begin
          grant_vld = 1'b1;
          grant_idx = SRC_W'(i);
          sel_op    = req_op[2*i +: 2];
          sel_src1  = req_src1[XLEN*i +: XLEN];
          sel_src2  = req_src2[XLEN*i +: XLEN];
          sel_tag   = req_tag[TAG_W*i +: TAG_W];
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_rdy[i] = accept && (grant_idx == SRC_W'(i));
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept) begin
      rr_ptr_d = (grant_idx == SRC_W'(NUM_REQ - 1)) ? '0 : grant_idx + SRC_W'(1);
    end
  end

  always_comb begin
    s1_vld_d  = s1_vld_q;
    s1_tc_a_d = s1_tc_a_q;
    s1_tc_b_d = s1_tc_b_q;
    s1_a_d    = s1_a_q;
    s1_b_d    = s1_b_q;
    s1_hi_d   = s1_hi_q;
    s1_tag_d  = s1_tag_q;
    s1_src_d  = s1_src_q;
    if (accept) begin
      s1_vld_d  = 1'b1;
      s1_tc_a_d = (op_e'(sel_op) == OP_MULH) || (op_e'(sel_op) == OP_MULHSU);
      s1_tc_b_d = (op_e'(sel_op) == OP_MULH);
      s1_a_d    = sel_src1;
      s1_b_d    = sel_src2;
      s1_hi_d   = sel_op[1] | sel_op[0];
      s1_tag_d  = sel_tag;
      s1_src_d  = grant_idx;
    end else if (s1_vld_q && s1_fwd) begin
      s1_vld_d = 1'b0;
    end
    if (flush) begin
      s1_vld_d = 1'b0;
    end
  end

  assign mul_tc_a = s1_tc_a_q;
  assign mul_tc_b = s1_tc_b_q;
  assign mul_a    = s1_a_q;
  assign mul_b    = s1_b_q;

`ifdef MUL_PRODUCT_RETIME_EN
  logic              s1b_adv;
  logic              s1b_vld_q, s1b_vld_d;
  logic [2*XLEN-1:0] s1b_prod_q, s1b_prod_d;
  logic              s1b_hi_q, s1b_hi_d;
  logic [TAG_W-1:0]  s1b_tag_q, s1b_tag_d;
  logic [SRC_W-1:0]  s1b_src_q, s1b_src_d;

  assign s1b_adv = !s1b_vld_q || s2_adv;
  assign s1_fwd  = s1b_adv;

  always_comb begin
    s1b_vld_d  = s1b_vld_q;
    s1b_prod_d = s1b_prod_q;
    s1b_hi_d   = s1b_hi_q;
    s1b_tag_d  = s1b_tag_q;
    s1b_src_d  = s1b_src_q;
    if (s1_vld_q && s1b_adv) begin
      s1b_vld_d  = 1'b1;
      s1b_prod_d = mul_product;
      s1b_hi_d   = s1_hi_q;
      s1b_tag_d  = s1_tag_q;
      s1b_src_d  = s1_src_q;
    end else if (s1b_vld_q && s2_adv) begin
      s1b_vld_d = 1'b0;
    end
    if (flush) begin
      s1b_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1b_vld_q  <= 1'b0;
      s1b_prod_q <= '0;
      s1b_hi_q   <= 1'b0;
      s1b_tag_q  <= '0;
      s1b_src_q  <= '0;
    end else begin
      s1b_vld_q  <= s1b_vld_d;
      s1b_prod_q <= s1b_prod_d;
      s1b_hi_q   <= s1b_hi_d;
      s1b_tag_q  <= s1b_tag_d;
      s1b_src_q  <= s1b_src_d;
    end
  end

  assign pre_vld  = s1b_vld_q;
  assign pre_prod = s1b_prod_q;
  assign pre_hi   = s1b_hi_q;
  assign pre_tag  = s1b_tag_q;
  assign pre_src  = s1b_src_q;
`else
  assign s1_fwd   = s2_adv;
  assign pre_vld  = s1_vld_q;
  assign pre_prod = mul_product;
  assign pre_hi   = s1_hi_q;
  assign pre_tag  = s1_tag_q;
  assign pre_src  = s1_src_q;
`endif

  // A consumed response with nothing behind it empties S2; an unconsumed one holds.
  always_comb begin
    s2_vld_d  = s2_vld_q;
    s2_data_d = s2_data_q;
    s2_tag_d  = s2_tag_q;
    s2_src_d  = s2_src_q;
    if (pre_vld && s2_adv) begin
      s2_vld_d  = 1'b1;
      s2_data_d = pre_hi ? pre_prod[2*XLEN-1:XLEN] : pre_prod[XLEN-1:0];
      s2_tag_d  = pre_tag;
      s2_src_d  = pre_src;
    end else if (rsp_rdy) begin
      s2_vld_d = 1'b0;
    end
    if (flush) begin
      s2_vld_d = 1'b0;
    end
  end

  assign rsp_vld  = s2_vld_q;
  assign rsp_data = s2_data_q;
  assign rsp_tag  = s2_tag_q;
  assign rsp_src  = s2_src_q;

  // NOTE: datapath registers are reset as well, so mul_* and rsp_* read zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q  <= '0;
      s1_vld_q  <= 1'b0;
      s1_tc_a_q <= 1'b0;
      s1_tc_b_q <= 1'b0;
      s1_a_q    <= '0;
      s1_b_q    <= '0;
      s1_hi_q   <= 1'b0;
      s1_tag_q  <= '0;
      s1_src_q  <= '0;
      s2_vld_q  <= 1'b0;
      s2_data_q <= '0;
      s2_tag_q  <= '0;
      s2_src_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      rr_ptr_q  <= rr_ptr_d;
      s1_vld_q  <= s1_vld_d;
      s1_tc_a_q <= s1_tc_a_d;
      s1_tc_b_q <= s1_tc_b_d;
      s1_a_q    <= s1_a_d;
      s1_b_q    <= s1_b_d;
      s1_hi_q   <= s1_hi_d;
      s1_tag_q  <= s1_tag_d;
      s1_src_q  <= s1_src_d;
      s2_vld_q  <= s2_vld_d;
      s2_data_q <= s2_data_d;
      s2_tag_q  <= s2_tag_d;
      s2_src_q  <= s2_src_d;
    end
  end

endmodule

// File: tb/tb_mul_issue_sched.sv
// Self-checking bench for mul_issue_sched: queue-based transaction model compared every cycle,
// plus directed vectors with hand-computed results.
module tb_mul_issue_sched;
  localparam int NUM_REQ = 2;
  localparam int XLEN    = 32;
  localparam int TAG_W   = 6;
  localparam int SW      = 1;
`ifdef MUL_PRODUCT_RETIME_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic                     clk   = 1'b0;
  logic                     rst_n = 1'b1;
  logic                     flush = 1'b0;
  logic [NUM_REQ-1:0]       req_vld = '0;
  logic [NUM_REQ-1:0]       req_rdy;
  logic [2*NUM_REQ-1:0]     req_op;
  logic [XLEN*NUM_REQ-1:0]  req_src1;
  logic [XLEN*NUM_REQ-1:0]  req_src2;
  logic [TAG_W*NUM_REQ-1:0] req_tag;
  logic                     mul_tc_a, mul_tc_b;
  logic [XLEN-1:0]          mul_a, mul_b;
  logic [2*XLEN-1:0]        mul_product;
  logic                     rsp_vld;
  logic                     rsp_rdy = 1'b1;
  logic [XLEN-1:0]          rsp_data;
  logic [TAG_W-1:0]         rsp_tag;
  logic [SW-1:0]            rsp_src;

  logic [1:0]       t_op  [NUM_REQ];
  logic [XLEN-1:0]  t_a   [NUM_REQ];
  logic [XLEN-1:0]  t_b   [NUM_REQ];
  logic [TAG_W-1:0] t_tag [NUM_REQ];
  logic [TAG_W-1:0] tag_ctr = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mul_issue_sched #(.NUM_REQ(NUM_REQ), .XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_op(req_op),
    .req_src1(req_src1), .req_src2(req_src2), .req_tag(req_tag),
    .mul_tc_a(mul_tc_a), .mul_tc_b(mul_tc_b), .mul_a(mul_a), .mul_b(mul_b),
    .mul_product(mul_product),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_data(rsp_data),
    .rsp_tag(rsp_tag), .rsp_src(rsp_src)
  );

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_op[2*i +: 2]           = t_op[i];
      req_src1[XLEN*i +: XLEN]   = t_a[i];
      req_src2[XLEN*i +: XLEN]   = t_b[i];
      req_tag[TAG_W*i +: TAG_W]  = t_tag[i];
    end
  end

  function automatic logic [63:0] smul(input logic [31:0] a, input logic [31:0] b,
                                       input logic sa, input logic sb);
    logic signed [65:0] ea, eb, p;
    ea = {{34{sa & a[31]}}, a};
    eb = {{34{sb & b[31]}}, b};
    p  = ea * eb;
    return p[63:0];
  endfunction

  // Shared multiplier the scheduler drives
  assign mul_product = smul(mul_a, mul_b, mul_tc_a, mul_tc_b);

  // RISC-V M semantics: MUL low half; MULH s*s, MULHSU s*u, MULHU u*u high half
  function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] p;
    p = smul(a, b, (op == 2'b01) || (op == 2'b10), op == 2'b01);
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction model: in-order list of in-flight ops, each with its pipeline position 1..LAT.
  typedef struct {
    logic [1:0]       op;
    logic [XLEN-1:0]  a;
    logic [XLEN-1:0]  b;
    logic [TAG_W-1:0] tag;
    int               src;
    int               pos;
  } ent_t;

  ent_t mq[$];
  int   m_rr = 0;

  function automatic int pick(input int rr, input logic [NUM_REQ-1:0] v);
    for (int k = 0; k < NUM_REQ; k++) begin
      int j;
      j = (rr + k) % NUM_REQ;
      if (v[j[SW-1:0]]) return j;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_rr = 0;
    end else if (flush) begin
      mq.delete();
    end else begin
      int   g;
      bit   acc;
      int   lim;
      ent_t e;
      g   = pick(m_rr, req_vld);
      acc = (g >= 0) && ((mq.size() < LAT) || rsp_rdy);
      if (mq.size() > 0 && mq[0].pos == LAT && rsp_rdy) void'(mq.pop_front());
      lim = LAT + 1;
      foreach (mq[i]) begin
        mq[i].pos = (mq[i].pos + 1 < lim) ? mq[i].pos + 1 : lim - 1;
        lim = mq[i].pos;
      end
      if (acc) begin
        e.op  = t_op[g[SW-1:0]];
        e.a   = t_a[g[SW-1:0]];
        e.b   = t_b[g[SW-1:0]];
        e.tag = t_tag[g[SW-1:0]];
        e.src = g;
        e.pos = 1;
        mq.push_back(e);
        m_rr = (g + 1) % NUM_REQ;
      end
    end
  end

  // Compare process: outputs settled mid-cycle, inputs stable since just after the rising edge
  always @(negedge clk) begin
    int         g;
    bit         acc;
    logic [1:0] exp_rdy;
    bit         exp_vld;
    ent_t       e;
    g       = pick(m_rr, req_vld);
    acc     = rst_n && !flush && (g >= 0) && ((mq.size() < LAT) || rsp_rdy);
    exp_rdy = acc ? (2'b01 << g) : 2'b00;
    check("req_rdy", req_rdy, exp_rdy);
    exp_vld = (mq.size() > 0) && (mq[0].pos == LAT);
    check("rsp_vld", rsp_vld, exp_vld);
    if (exp_vld) begin
      e = mq[0];
      check("rsp_data", rsp_data, ref_res(e.op, e.a, e.b));
      check("rsp_tag", rsp_tag, e.tag);
      check("rsp_src", rsp_src, e.src);
    end
    if (mq.size() > 0 && mq[mq.size()-1].pos == 1) begin
      e = mq[mq.size()-1];
      check("mul_a", mul_a, e.a);
      check("mul_b", mul_b, e.b);
      check("mul_tc", {mul_tc_a, mul_tc_b}, {(e.op == 2'b01) || (e.op == 2'b10), e.op == 2'b01});
    end
  end

  task automatic refresh(input logic [1:0] took);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (took[i[SW-1:0]]) begin
        t_op[i[SW-1:0]]  = 2'($urandom_range(0, 3));
        t_a[i[SW-1:0]]   = $urandom;
        t_b[i[SW-1:0]]   = $urandom;
        t_tag[i[SW-1:0]] = tag_ctr;
        tag_ctr++;
      end
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_req_rdy", req_rdy, 0);
    check("rst_rsp_vld", rsp_vld, 0);
    check("rst_mul_a", mul_a, 0);
    check("rst_mul_b", mul_b, 0);
    check("rst_mul_tc", {mul_tc_a, mul_tc_b}, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_tag", rsp_tag, 0);
    check("rst_rsp_src", rsp_src, 0);
  endtask

  // Single op on requester 0 into an idle pipeline; expects a literal result after LAT edges.
  task automatic run_single(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [5:0] t, input logic [31:0] exp);
    int lat;
    @(posedge clk); #1;
    t_op[0] = op; t_a[0] = a; t_b[0] = b; t_tag[0] = t;
    req_vld = 2'b01;
    @(posedge clk); #1;
    req_vld = 2'b00;
    lat = 1;
    while (!rsp_vld && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("single_latency", lat, LAT);
    check("single_data", rsp_data, exp);
    check("single_tag", rsp_tag, t);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] took;
    int         n_acc;
    refresh(2'b11);

    // Reset state, with requests already pending
    #2 rst_n = 1'b0;
    req_vld = 2'b11;
    #10;
    check_reset_outputs();
    @(posedge clk); #1;
    req_vld = 2'b00;
    rst_n   = 1'b1;

    // Directed arithmetic
    run_single(2'b00, 32'hFFFF_FFFF, 32'h0000_0002, 6'h2A, 32'hFFFF_FFFE);
    run_single(2'b01, 32'h8000_0000, 32'h8000_0000, 6'h11, 32'h4000_0000);
    run_single(2'b11, 32'h8000_0000, 32'h8000_0000, 6'h12, 32'h4000_0000);
    run_single(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'h13, 32'hFFFF_FFFF);
    run_single(2'b01, 32'hFFFF_FFFF, 32'h0000_0003, 6'h14, 32'hFFFF_FFFF);

    // Both requesting every cycle: last grant was to 0, so grants go 1,0,1,0,...
    refresh(2'b11);
    req_vld = 2'b11;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check("rr_alternate", req_rdy, (c % 2 == 0) ? 2'b10 : 2'b01);
      took = req_rdy;
      @(posedge clk); #1;
      refresh(took);
    end
    req_vld = 2'b00;
    repeat (LAT + 2) @(posedge clk);
    #1;

    // Backpressure: only as many ops as pipeline stages get in
    rsp_rdy = 1'b0;
    req_vld = 2'b11;
    n_acc   = 0;
    repeat (5) begin
      @(negedge clk);
      took = req_rdy;
      if (took != 2'b00) n_acc++;
      @(posedge clk); #1;
      refresh(took);
    end
    check("bp_accept_count", n_acc, LAT);
    req_vld = 2'b00;
    rsp_rdy = 1'b1;
    repeat (LAT + 2) @(posedge clk);
    #1;

    // Flush with every stage full; requester 0 fills, so rr points at 1 afterwards
    rsp_rdy = 1'b0;
    req_vld = 2'b01;
    repeat (LAT) begin
      @(negedge clk);
      took = req_rdy;
      @(posedge clk); #1;
      refresh(took);
    end
    flush   = 1'b1;
    rsp_rdy = 1'b1;
    req_vld = 2'b11;
    @(negedge clk);
    check("flush_rdy_low", req_rdy, 2'b00);
    check("full_before_flush", rsp_vld, 1);
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_clears_rsp", rsp_vld, 0);
    @(negedge clk);
    check("rr_kept_over_flush", req_rdy, 2'b10);
    took = req_rdy;
    @(posedge clk); #1;
    refresh(took);
    req_vld = 2'b00;
    repeat (LAT + 2) @(posedge clk);
    #1;

    // Async reset mid-stream; grants 0,1,0 leave rr at 1 beforehand
    req_vld = 2'b11;
    repeat (3) begin
      @(negedge clk);
      took = req_rdy;
      @(posedge clk); #1;
      refresh(took);
    end
    #3 rst_n = 1'b0;
    #1;
    check_reset_outputs();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("first_grant_after_reset", req_rdy, 2'b01);
    took = req_rdy;
    @(posedge clk); #1;
    refresh(took);
    req_vld = 2'b00;
    repeat (LAT + 3) @(posedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
